// File: rtl/dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scoreboard
// Description : Decode-stage issue control for a dual-issue pipeline. Keeps a
//               per-register count of in-flight writers, applies same-cycle
//               writeback releases as a bypass, and decides whether the
//               decoded pair issues both slots, only slot A, or neither.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_valid,
  input  logic            a_we,
  input  logic [AW-1:0]   a_ra1,
  input  logic [AW-1:0]   a_ra2,
  input  logic [AW-1:0]   a_wa,
  input  logic            b_valid,
  input  logic            b_we,
  input  logic [AW-1:0]   b_ra1,
  input  logic [AW-1:0]   b_ra2,
  input  logic [AW-1:0]   b_wa,
  input  logic            ex_ready,
  input  logic            rel1,
  input  logic [AW-1:0]   rel1_wa,
  input  logic            rel2,
  input  logic [AW-1:0]   rel2_wa,
  output logic            issue_a,
  output logic            issue_b,
  output logic            b_hold,
  output logic [NREG-1:0] pending,
  output logic            err
);

  localparam logic [CW-1:0] CMAX = '1;

  // Register 0 is hardwired zero, so it owns no counter flop.
  logic [CW-1:0]   cnt_q [1:NREG-1];
  logic [CW-1:0]   cnt_d [1:NREG-1];
  logic [CW-1:0]   eff   [NREG];
  logic [CW:0]     dec_v;
  logic [NREG-1:0] under;
  logic [NREG-1:0] pending_q, pending_d;
  logic            err_q, err_d;
  logic            raw_a, raw_b, ovf_a, ovf_b, pair_raw, pair_waw;

  // Effective counts after this cycle's releases; releases land on the
  // falling edge in the register file, so they resolve hazards immediately.
  always_comb begin
    eff[0] = '0;
    under  = '0;
    dec_v  = '0;
    for (int r = 1; r < NREG; r++) begin
      dec_v = (CW+1)'(rel1 && (rel1_wa == AW'(r))) + (CW+1)'(rel2 && (rel2_wa == AW'(r)));
      if (dec_v > {1'b0, cnt_q[r]}) begin
        eff[r]   = '0;
        under[r] = 1'b1;
      end else begin
        eff[r] = CW'({1'b0, cnt_q[r]} - dec_v);
      end
    end
  end

  // Hazard detection and the issue decision for the decoded pair.
  always_comb begin
    raw_a    = ((a_ra1 != '0) && (eff[a_ra1] != '0)) ||
               ((a_ra2 != '0) && (eff[a_ra2] != '0));
    raw_b    = ((b_ra1 != '0) && (eff[b_ra1] != '0)) ||
               ((b_ra2 != '0) && (eff[b_ra2] != '0));
    ovf_a    = a_we && (a_wa != '0) && (eff[a_wa] == CMAX);
    ovf_b    = b_we && (b_wa != '0) && (eff[b_wa] == CMAX);
    pair_raw = a_we && (a_wa != '0) && ((b_ra1 == a_wa) || (b_ra2 == a_wa));
    pair_waw = a_we && b_we && (a_wa == b_wa) && (a_wa != '0);
    issue_a  = reset_n && ex_ready && a_valid && !raw_a && !ovf_a;
    issue_b  = issue_a && b_valid && !raw_b && !ovf_b && !pair_raw && !pair_waw;
    b_hold   = issue_a && b_valid && !issue_b;
  end

  // Next counts: released count plus at most one new writer per register
  // (a same-register pair is blocked by the WAW check).
  always_comb begin
    pending_d    = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r]     = eff[r]
                   + CW'(issue_a && a_we && (a_wa == AW'(r)))
                   + CW'(issue_b && b_we && (b_wa == AW'(r)));
      pending_d[r] = (cnt_d[r] != '0);
    end
    err_d = err_q | (|under);
  end

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      // Per-register pending-writer counter.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q[r] <= '0;
        else          cnt_q[r] <= cnt_d[r];
      end
    end
  endgenerate

  // Registered pending map and sticky underflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scoreboard
// Description : Directed self-checking bench for dual_issue_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            a_valid, a_we, b_valid, b_we, ex_ready, rel1, rel2;
  logic [AW-1:0]   a_ra1, a_ra2, a_wa, b_ra1, b_ra2, b_wa, rel1_wa, rel2_wa;
  logic            issue_a, issue_b, b_hold, err;
  logic [NREG-1:0] pending;
  logic [2:0]      iss;

  assign iss = {issue_a, issue_b, b_hold};

  always #5 clk = ~clk;

  dual_issue_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_we(a_we), .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa),
    .b_valid(b_valid), .b_we(b_we), .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa),
    .ex_ready(ex_ready),
    .rel1(rel1), .rel1_wa(rel1_wa), .rel2(rel2), .rel2_wa(rel2_wa),
    .issue_a(issue_a), .issue_b(issue_b), .b_hold(b_hold),
    .pending(pending), .err(err)
  );

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) passed++;
      else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    a_valid = 0; a_we = 0; a_ra1 = 0; a_ra2 = 0; a_wa = 0;
    b_valid = 0; b_we = 0; b_ra1 = 0; b_ra2 = 0; b_wa = 0;
    rel1 = 0; rel1_wa = 0; rel2 = 0; rel2_wa = 0;
    ex_ready = 1;
  endtask

  // Expected {issue_a, issue_b, b_hold} for the inputs currently driven.
  task automatic comb(input string tag, input logic [2:0] e);
    push(tag, {29'b0, e});
    #1;
    pop_chk({29'b0, iss});
  endtask

  // Expected registered outputs after the next rising edge.
  task automatic tick(input string tag, input logic [31:0] pend, input logic e);
    push({tag, "_pend"}, pend);
    push({tag, "_err"}, {31'b0, e});
    @(posedge clk);
    #1;
    pop_chk(pending);
    pop_chk({31'b0, err});
    @(negedge clk);
  endtask

  task automatic write_a(input logic [AW-1:0] wa);
    idle();
    a_valid = 1; a_we = 1; a_wa = wa;
  endtask

  initial begin
    reset_n = 0;
    idle();
    a_valid = 1; a_we = 1; a_wa = 1;
    comb("rst_iss", 3'b000);
    tick("rst", 32'h0, 1'b0);
    reset_n = 1;

    // A writes r5
    write_a(5);
    comb("a_w5", 3'b100);
    tick("a_w5", 32'h1 << 5, 1'b0);

    // A reads r5: stall, then same-cycle release bypass
    idle();
    a_valid = 1; a_ra1 = 5; b_valid = 1;
    comb("raw_r5", 3'b000);
    rel1 = 1; rel1_wa = 5;
    comb("raw_r5_bypass", 3'b110);
    tick("rel_r5", 32'h0, 1'b0);

    // Intra-pair RAW
    write_a(3);
    b_valid = 1; b_ra1 = 3;
    comb("pair_raw", 3'b101);
    tick("pair_raw", 32'h1 << 3, 1'b0);

    // Intra-pair WAW
    write_a(3);
    b_valid = 1; b_we = 1; b_wa = 3;
    comb("pair_waw", 3'b101);
    tick("pair_waw", 32'h1 << 3, 1'b0);

    // Both write r0 while r3 is doubly released
    write_a(0);
    b_valid = 1; b_we = 1; b_wa = 0;
    rel1 = 1; rel1_wa = 3; rel2 = 1; rel2_wa = 3;
    comb("both_r0", 3'b110);
    tick("both_r0", 32'h0, 1'b0);

    // Three writers of r7 fill the counter
    for (int i = 0; i < 3; i++) begin
      write_a(7);
      comb($sformatf("w7_%0d", i), 3'b100);
      tick($sformatf("w7_%0d", i), 32'h1 << 7, 1'b0);
    end
    write_a(7);
    comb("w7_ovf", 3'b000);
    rel2 = 1; rel2_wa = 7;
    comb("w7_ovf_bypass", 3'b100);
    tick("w7_swap", 32'h1 << 7, 1'b0);
    write_a(7);
    comb("w7_still_full", 3'b000);
    rel1 = 1; rel1_wa = 7; a_valid = 0;
    rel2 = 1; rel2_wa = 7;
    tick("w7_drain2", 32'h1 << 7, 1'b0);
    idle();
    rel1 = 1; rel1_wa = 7;
    tick("w7_drain1", 32'h0, 1'b0);

    // ex_ready low blocks issue and increment
    write_a(6);
    ex_ready = 0;
    comb("ex_stall", 3'b000);
    tick("ex_stall", 32'h0, 1'b0);

    // Double release of a singly-held r9 underflows
    write_a(9);
    comb("w9", 3'b100);
    tick("w9", 32'h1 << 9, 1'b0);
    idle();
    rel1 = 1; rel1_wa = 9; rel2 = 1; rel2_wa = 9;
    tick("r9_under", 32'h0, 1'b1);
    idle();
    tick("err_sticky", 32'h0, 1'b1);

    // Build cnt[4]=2, then asynchronous reset mid-cycle
    write_a(4);
    tick("w4_0", 32'h1 << 4, 1'b1);
    write_a(4);
    tick("w4_1", 32'h1 << 4, 1'b1);
    write_a(8);
    comb("pre_rst", 3'b100);
    reset_n = 0;
    comb("async_rst_iss", 3'b000);
    push("async_rst_pend", 32'h0);
    push("async_rst_err", 32'h0);
    #1;
    pop_chk(pending);
    pop_chk({31'b0, err});
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    write_a(4);
    comb("post_rst_w4", 3'b100);
    tick("post_rst_w4", 32'h1 << 4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dual_issue_scoreboard.md
# dual_issue_scoreboard

Issue-control block in the decode stage of the dual-issue pipeline, directly upstream of the two-slot register file read ports. It tracks pending register writes for every in-flight instruction with per-register counters, then decides each cycle whether the decoded pair issues both slots, only the older slot, or neither. Writeback release ports return registers as the register file write ports commit them on the falling clock edge, so a release counts as resolved in the same cycle.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width.
- CW, 2, pending-counter width; maximum count per register is CMAX = 2^CW-1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid, a_we  in  1 each  slot A (older) holds an instruction / writes a destination.
- a_ra1, a_ra2, a_wa  in  AW each  slot A sources and destination.
- b_valid, b_we, b_ra1, b_ra2, b_wa  in  1/1/AW/AW/AW  same fields for slot B (younger).
- ex_ready  in  1  execute stage can accept an issue this cycle.
- rel1, rel2  in  1 each  writeback release strobes (asserted for committed and squashed writers alike).
- rel1_wa, rel2_wa  in  AW each  released register numbers.
- issue_a, issue_b  out  1 each  slot issues this cycle (combinational).
- b_hold  out  1  A issues but B does not; decode re-presents B as slot A next cycle.
- pending  out  NREG  registered; bit r = (cnt[r] != 0).
- err  out  1  registered, sticky; set on a release to a register whose count is 0.

## Operation
- State: cnt[1..NREG-1], CW bits each, plus err. cnt[0] is constant 0 and is never incremented or decremented.
- Release count this cycle: dec[r] = (rel1 && rel1_wa==r) + (rel2 && rel2_wa==r), with a value from 0 to 2, and r=0 ignored.
- Effective count: eff[r] = cnt[r] - dec[r], floored at 0. Used for all hazard checks (release bypass).
- RAW on source s: s!=0 and eff[s]!=0.
- Overflow on a write: we && wa!=0 && eff[wa]==CMAX.
- issue_a = reset_n && ex_ready && a_valid && no RAW on a_ra1/a_ra2 && no overflow for A.
- issue_b = issue_a && b_valid && no RAW on b_ra1/b_ra2 && no overflow for B && no intra-pair conflict.
  - Intra-pair RAW: a_we && a_wa!=0 && (b_ra1==a_wa || b_ra2==a_wa).
  - Intra-pair WAW: a_we && b_we && a_wa==b_wa && a_wa!=0.
- b_hold = issue_a && b_valid && !issue_b.
- Source checks use the sources actually presented, so a slot that does not read a register must drive its address to 0.
- Next state per register: cnt[r] <= eff[r] + (issue_a && a_we && a_wa==r) + (issue_b && b_we && b_wa==r). The increment is at most 1, because intra-pair WAW is blocked. Overflow is prevented by the issue rule.
- Underflow: if dec[r] > cnt[r], err <= 1 and cnt[r] floors at 0.

## Timing
- Reset (reset_n low, asynchronous): all cnt=0, pending=0, err=0. issue_a, issue_b and b_hold are forced to 0 while reset_n is low.
- Issue decision has zero latency: combinational from inputs and current cnt.
- A counter increments on the rising edge that ends the issue cycle, so a dependent instruction presented the next cycle stalls.
- A release in cycle n clears the hazard within cycle n, matching the register file's falling-edge write. pending reflects it from edge n+1.
- Simultaneous events:
  - Issue and release of the same register in one cycle: net change is inc - dec.
  - Two releases of one register in one cycle: decrement by 2.
- ex_ready low: no issue and no increment; releases still apply.
- Reset asserted mid-operation: all counts are lost. The pipeline must be flushed alongside, because later releases would raise err.

## Test plan
- Reset release, then A writes r5 (a_we=1, a_wa=5) with ex_ready=1 -> issue_a=1. Next cycle pending[5]=1 and cnt[5]=1.
- A reads r5 while cnt[5]=1 with no release -> issue_a=0, issue_b=0. Same cycle with rel1=1, rel1_wa=5 -> issue_a=1.
- Pair A writes r3, B reads r3 -> issue_a=1, issue_b=0, b_hold=1. Pair A writes r3, B writes r3 -> b_hold=1. Both write r0 -> both issue, pending stays 0.
- Issue three writers of r7 with no release (CMAX=3), then a fourth -> fourth gets issue_a=0. rel2 on r7 in the same cycle -> fourth issues and cnt[7] stays 3.
- cnt[9]=1, rel1 and rel2 both on r9 in one cycle -> cnt[9]=0 and err=1, staying set until reset_n=0.
- cnt[4]=2 with reset_n pulsed low mid-cycle -> pending=0, err=0 and issue outputs 0 immediately, without waiting for a clock edge.
